// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e           : FSM state encoding (IDLE / RUN / DONE)
//   DIV_RESULT_READY/...  : levels of ready_o
//   DIV_START/DIV_STOP    : levels of start_i
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step (purely combinational).
//   rem      in  WIDTH  partial remainder, always < divisor
//   dvd_bit  in  1      next dividend bit, MSB first
//   divisor  in  WIDTH  magnitude of the divisor (non-zero)
//   rem_next out WIDTH  partial remainder after this step
//   q_bit    out 1      quotient bit produced by this step
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // The shifted remainder needs WIDTH+1 bits so the compare cannot overflow.
  assign partial = {rem, dvd_bit};
  assign diff    = partial - {1'b0, divisor};

  // Because rem < divisor, partial < 2*divisor: a successful subtract leaves
  // the top bit clear and a failed one always borrows into it, so the top
  // bit of the difference doubles as the compare result.
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   clk          in  1        clock, rising edge
//   rst          in  1        asynchronous reset, active-high
//   signed_div_i in  1        1 = two's-complement operands
//   opdata1_i    in  WIDTH    dividend
//   opdata2_i    in  WIDTH    divisor
//   start_i      in  1        request, held until ready_o
//   annul_i      in  1        abort current/pending division
//   result_o     out 2*WIDTH  {remainder, quotient}
//   ready_o      out 1        result_o valid (DONE state)
//   busy_o       out 1        iterating (RUN state)
// Divide-by-zero and signed overflow resolve in one cycle with the RISC-V
// results; everything else takes WIDTH steps on operand magnitudes, with the
// signs applied on the last step.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  div_state_e state, state_next;

  // dvd shifts out dividend bits at the top while quotient bits shift in at
  // the bottom, so after WIDTH steps it holds the unsigned quotient.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic             req;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, overflow, last_step;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_raw, q_final, r_final;

  assign req       = (start_i == DIV_START) && !annul_i;
  assign sa        = signed_div_i & opdata1_i[WIDTH-1];
  assign sb        = signed_div_i & opdata2_i[WIDTH-1];
  assign abs_a     = sa ? -opdata1_i : opdata1_i;
  assign abs_b     = sb ? -opdata2_i : opdata2_i;
  assign div_zero  = (opdata2_i == '0);
  assign overflow  = signed_div_i && (opdata1_i == MIN_VAL) && (opdata2_i == ONES);
  assign last_step = (cnt == LAST);

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[WIDTH-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_raw   = {dvd[WIDTH-2:0], q_bit};
  assign q_final = neg_q ? -q_raw : q_raw;
  assign r_final = neg_r ? -rem_next : rem_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  // NOTE: next state is defaulted first so no path through the case leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: if (req) state_next = (div_zero || overflow) ? DIV_DONE : DIV_RUN;
      DIV_RUN: begin
        if (!req)           state_next = DIV_IDLE;
        else if (last_step) state_next = DIV_DONE;
      end
      DIV_DONE: if (!req) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, not just the FSM, so the outputs
  // are defined immediately and no X can leak out after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (req) begin
            if (div_zero) begin
              result_o <= {opdata1_i, ONES};
            end else if (overflow) begin
              result_o <= {{WIDTH{1'b0}}, MIN_VAL};
            end else begin
              dvd   <= abs_a;
              dsr   <= abs_b;
              rem   <= '0;
              cnt   <= '0;
              neg_q <= sa ^ sb;
              neg_r <= sa;
            end
          end
        end
        DIV_RUN: begin
          if (req) begin
            rem <= rem_next;
            dvd <= q_raw;
            cnt <= cnt + CW'(1);
            if (last_step) result_o <= {r_final, q_final};
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (state == DIV_DONE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign busy_o  = (state == DIV_RUN);

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: one WIDTH=32 and one WIDTH=8 instance on a shared clock
// and reset, directed cases followed by randomized operands, all compared
// against an arithmetic reference model.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;

  logic        s32, st32, an32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        rdy32, bsy32;

  logic        s8, st8, an8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8, bsy8;

  int n_checks = 0;
  int n_err    = 0;

  // Last expected {r, q} of each instance, zero-extended to 64 bits each.
  logic [63:0] exp_q32, exp_r32, exp_q8, exp_r8;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(s32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32), .busy_o(bsy32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8), .busy_o(bsy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V division semantics on w-bit operands using 64-bit math.
  task automatic model(input int w, input bit sgn, input logic [63:0] a_in, input logic [63:0] b_in,
                       output logic [63:0] q, output logic [63:0] r, output bit special);
    logic [63:0] mask, min, a, b;
    logic signed [63:0] as_, bs;
    mask = (64'd1 << w) - 64'd1;
    min  = 64'd1 << (w - 1);
    a    = a_in & mask;
    b    = b_in & mask;
    special = 1'b0;
    if (b == 0) begin
      q = mask; r = a; special = 1'b1;
    end else if (sgn && a == min && b == mask) begin
      q = min; r = 0; special = 1'b1;
    end else if (sgn) begin
      as_ = $signed(a << (64 - w)) >>> (64 - w);
      bs  = $signed(b << (64 - w)) >>> (64 - w);
      q = as_ / bs;
      r = as_ % bs;
    end else begin
      q = a / b;
      r = a % b;
    end
    q = q & mask;
    r = r & mask;
  endtask

  task automatic sample(input bit w8, output logic rdy, output logic bsy,
                        output logic [63:0] q, output logic [63:0] r);
    if (w8) begin
      rdy = rdy8; bsy = bsy8; q = {56'd0, res8[7:0]};  r = {56'd0, res8[15:8]};
    end else begin
      rdy = rdy32; bsy = bsy32; q = {32'd0, res32[31:0]}; r = {32'd0, res32[63:32]};
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with start_i low.
  task automatic run_op(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit hold);
    int w, cyc, busy_n;
    logic [63:0] eq, er, oq, or_;
    logic rdy, bsy;
    bit sp;
    w = w8 ? 8 : 32;
    model(w, sgn, {32'd0, a}, {32'd0, b}, eq, er, sp);
    if (w8) begin s8 = sgn; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; exp_q8 = eq; exp_r8 = er; end
    else    begin s32 = sgn; a32 = a; b32 = b; st32 = 1'b1; exp_q32 = eq; exp_r32 = er; end
    cyc = 0; busy_n = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      sample(w8, rdy, bsy, oq, or_);
      if (bsy) busy_n++;
    end while (!rdy && cyc < 200);
    check({tag, "/latency"}, 64'(cyc), sp ? 64'd1 : 64'(w + 1));
    check({tag, "/busy_cycles"}, 64'(busy_n), sp ? 64'd0 : 64'(w));
    check({tag, "/q"}, oq, eq);
    check({tag, "/r"}, or_, er);
    if (hold) begin
      @(posedge clk); #1;
      sample(w8, rdy, bsy, oq, or_);
      check({tag, "/hold_ready"}, {63'd0, rdy}, 64'd1);
      check({tag, "/hold_q"}, oq, eq);
    end
    if (w8) st8 = 1'b0; else st32 = 1'b0;
    @(posedge clk); #1;
    sample(w8, rdy, bsy, oq, or_);
    check({tag, "/ready_drop"}, {63'd0, rdy}, 64'd0);
    check({tag, "/idle_hold_q"}, oq, eq);
  endtask

  initial begin
    int hits;
    logic [31:0] ra, rb;
    rst = 1'b1;
    s32 = 0; st32 = 0; an32 = 0; a32 = 0; b32 = 0;
    s8 = 0;  st8 = 0;  an8 = 0;  a8 = 0;  b8 = 0;
    #2;
    check("reset/res32", res32, 64'd0);
    check("reset/res8", {48'd0, res8}, 64'd0);
    check("reset/flags", {60'd0, rdy32, bsy32, rdy8, bsy8}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(1'b0, 1'b0, 32'd100, 32'd7, "u100_7", 1'b1);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "s-7_2", 1'b0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, "uFFFFFFF9_2", 1'b0);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, "s5_0", 1'b0);
    run_op(1'b0, 1'b0, 32'd5, 32'd0, "u5_0", 1'b1);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "smin_-1", 1'b0);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "umin_-1", 1'b0);

    // Annul in the middle of RUN: result must stay at the previous value.
    s32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; st32 = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("annul/busy_before", {63'd0, bsy32}, 64'd1);
    an32 = 1'b1;
    @(posedge clk); #1;
    check("annul/busy_after", {63'd0, bsy32}, 64'd0);
    check("annul/ready_after", {63'd0, rdy32}, 64'd0);
    an32 = 1'b0; st32 = 1'b0;
    hits = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy32) hits++;
    end
    check("annul/no_ready", 64'(hits), 64'd0);
    check("annul/result_kept", res32, {exp_r32[31:0], exp_q32[31:0]});
    run_op(1'b0, 1'b0, 32'd9, 32'd3, "u9_3", 1'b0);

    // Asynchronous reset in the middle of RUN.
    s32 = 1'b0; a32 = 32'd1000; b32 = 32'd7; st32 = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst/res32", res32, 64'd0);
    check("midrst/flags", {62'd0, rdy32, bsy32}, 64'd0);
    st32 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(1'b0, 1'b0, 32'd1, 32'd1, "u1_1", 1'b0);

    run_op(1'b1, 1'b0, 32'd200, 32'd3, "w8_u200_3", 1'b0);
    run_op(1'b1, 1'b1, 32'h80, 32'hFF, "w8_s-128_-1", 1'b0);
    run_op(1'b1, 1'b1, 32'h81, 32'h07, "w8_s-127_7", 1'b0);

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < 2; k++) begin
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 9))
          0: rb = 32'd0;
          1: rb = 32'hFFFF_FFFF;
          2: ra = (k == 0) ? 32'h8000_0000 : 32'h80;
          3: rb = $urandom_range(1, 15);
          default: ;
        endcase
        if (k == 1 && rb[7:0] == 8'd0 && ($urandom_range(0, 1) == 1)) rb[0] = 1'b1;
        run_op(k == 1, 1'($urandom_range(0, 1)), ra, rb, (k == 1) ? "rand8" : "rand32",
               1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
